uart_reg_ctrl: RTL and testbench

UART_REG_CTRL -- requirements
Module: uart_reg_ctrl

---
 rtl/uart_reg_ctrl.sv | 131 +++++++++++++
 tb/tb_uart_reg_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_ctrl.sv
// CPU-side register access controller: a three-state handshake (IDLE/STROBE/RESP)
// that strobes one register per access and counts peripheral writes lost to the CPU.
module uart_reg_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           req_i,
  input  logic                           we_i,
  input  logic [ADDR_WIDTH-1:0]          addr_i,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  output logic                           ack_o,
  output logic                           err_o,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  output logic                           busy_o,
  output logic [NUM_REGS-1:0]            reg_wr_en_o,
  output logic [NUM_REGS-1:0]            reg_rd_en_o,
  output logic [DATA_WIDTH-1:0]          reg_wdata_o,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_data_i,
  input  logic [NUM_REGS-1:0]            periph_wr_en_i,
  output logic [7:0]                     collision_cnt_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                  state_reg;
  state_t                  state_next;
  logic                    we_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg;
  logic [DATA_WIDTH-1:0]   rdata_next;
  logic [7:0]              collision_cnt_reg;
  logic [NUM_REGS-1:0]     sel_onehot;
  logic                    addr_valid;
  logic                    collision_hit;
  logic [DATA_WIDTH-1:0]   reg_slice [NUM_REGS];

  // One select bit per served register; an out-of-range address selects none.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_slot
      assign reg_slice[gi]  = reg_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
      assign sel_onehot[gi] = (addr_reg == ADDR_WIDTH'(gi));
    end
  endgenerate

  assign addr_valid    = |sel_onehot;
  assign collision_hit = (state_reg == STROBE) && we_reg && |(sel_onehot & periph_wr_en_i);

  always_comb begin
    rdata_next = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (sel_onehot[k]) begin
        rdata_next = reg_slice[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_i) state_next = STROBE;
      STROBE:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields are captured only in IDLE; read data is taken in STROBE,
  // i.e. before any read-clear side effect of the enable becomes visible.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_reg            <= 1'b0;
      addr_reg          <= '0;
      wdata_reg         <= '0;
      rdata_reg         <= '0;
      collision_cnt_reg <= '0;
    end else begin
      if (state_reg == IDLE && req_i) begin
        we_reg    <= we_i;
        addr_reg  <= addr_i;
        wdata_reg <= wdata_i;
      end
      if (state_reg == STROBE) begin
        rdata_reg <= we_reg ? '0 : rdata_next;
      end
      if (collision_hit && collision_cnt_reg != 8'hFF) begin
        collision_cnt_reg <= collision_cnt_reg + 8'd1;
      end
    end
  end

  always_comb begin
    ack_o       = 1'b0;
    err_o       = 1'b0;
    rdata_o     = '0;
    reg_wr_en_o = '0;
    reg_rd_en_o = '0;
    case (state_reg)
      STROBE: begin
        if (we_reg) reg_wr_en_o = sel_onehot;
        else        reg_rd_en_o = sel_onehot;
      end
      RESP: begin
        ack_o = 1'b1;
        err_o = ~addr_valid;
        if (!we_reg && addr_valid) rdata_o = rdata_reg;
      end
      default: ;
    endcase
  end

  assign busy_o          = (state_reg != IDLE);
  assign reg_wdata_o     = wdata_reg;
  assign collision_cnt_o = collision_cnt_reg;

endmodule

// File: tb/tb_uart_reg_ctrl.sv
// Scoreboard bench for uart_reg_ctrl: expectations are queued when a request is
// driven and compared when the DUT acknowledges.
module tb_uart_reg_ctrl;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 4;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              req_i;
  logic              we_i;
  logic [AW-1:0]     addr_i;
  logic [DW-1:0]     wdata_i;
  logic              ack_o;
  logic              err_o;
  logic [DW-1:0]     rdata_o;
  logic              busy_o;
  logic [NR-1:0]     reg_wr_en_o;
  logic [NR-1:0]     reg_rd_en_o;
  logic [DW-1:0]     reg_wdata_o;
  logic [NR*DW-1:0]  reg_data_i;
  logic [NR-1:0]     periph_wr_en_i;
  logic [7:0]        collision_cnt_o;

  uart_reg_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .ack_o(ack_o), .err_o(err_o), .rdata_o(rdata_o),
    .busy_o(busy_o), .reg_wr_en_o(reg_wr_en_o), .reg_rd_en_o(reg_rd_en_o),
    .reg_wdata_o(reg_wdata_o), .reg_data_i(reg_data_i),
    .periph_wr_en_i(periph_wr_en_i), .collision_cnt_o(collision_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] rdata;
    logic [DW-1:0] wdata;
    logic [NR-1:0] wr_en;
    logic [NR-1:0] rd_en;
    logic [7:0]    cnt;
  } exp_t;

  exp_t          exp_q[$];
  int unsigned   ack_cyc[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int unsigned   cyc = 0;
  logic [NR-1:0] seen_wr = '0;
  logic [NR-1:0] seen_rd = '0;
  logic [7:0]    cnt_model = '0;
  logic [DW-1:0] slot_val [NR];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    logic valid;
    valid   = (a < AW'(NR));
    e.err   = ~valid;
    e.wdata = d;
    e.rdata = '0;
    e.wr_en = '0;
    e.rd_en = '0;
    if (valid) begin
      if (we) begin
        e.wr_en = NR'(1) << a;
        if (periph_wr_en_i[a[1:0]] && cnt_model != 8'hFF) cnt_model = cnt_model + 8'd1;
      end else begin
        e.rd_en = NR'(1) << a;
        e.rdata = slot_val[a[1:0]];
      end
    end
    e.cnt = cnt_model;
    return e;
  endfunction

  // Monitor: enables seen in STROBE, response compared in RESP.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (busy_o && !ack_o) begin
      seen_wr = reg_wr_en_o;
      seen_rd = reg_rd_en_o;
    end else if ((reg_wr_en_o | reg_rd_en_o) != '0) begin
      check_val("en_outside_strobe", {reg_wr_en_o, reg_rd_en_o}, '0);
    end
    if (ack_o) begin
      ack_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check_val("unexpected_ack", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_val("err", err_o, e.err);
        check_val("rdata", rdata_o, e.rdata);
        check_val("wdata_out", reg_wdata_o, e.wdata);
        check_val("wr_en", seen_wr, e.wr_en);
        check_val("rd_en", seen_rd, e.rd_en);
        check_val("coll_cnt", collision_cnt_o, e.cnt);
        $display("txn cyc=%0d err=%0b rdata=%08h wr_en=%b rd_en=%b cnt=%0d",
                 cyc, err_o, rdata_o, seen_wr, seen_rd, collision_cnt_o);
      end
      seen_wr = '0;
      seen_rd = '0;
    end else if (err_o || rdata_o != '0) begin
      check_val("resp_without_ack", {31'd0, err_o, rdata_o}, '0);
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (busy_o) check_val("idle_timeout", 1, 0);
  endtask

  task automatic access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wait_idle();
    req_i = 1'b1; we_i = we; addr_i = a; wdata_i = d;
    exp_q.push_back(model(we, a, d));
    @(negedge clk);
    // Scrambled inputs during STROBE/RESP must not be observed.
    req_i = 1'b0; we_i = ~we; addr_i = ~a; wdata_i = ~d;
  endtask

  initial begin
    logic [AW-1:0] b2b_addr [9];
    int base;
    int n;
    slot_val[0] = 32'h1111_0000;
    slot_val[1] = 32'hDEAD_BEEF;
    slot_val[2] = 32'h0000_00FF;
    slot_val[3] = 32'h8000_0003;
    for (int k = 0; k < NR; k++) reg_data_i[k*DW +: DW] = slot_val[k];
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; periph_wr_en_i = '0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    check_val("rst_ack", ack_o, 0);
    check_val("rst_busy", busy_o, 0);
    check_val("rst_cnt", collision_cnt_o, 0);
    check_val("rst_rdata", rdata_o, 0);
    check_val("rst_wdata", reg_wdata_o, 0);
    check_val("rst_en", {reg_wr_en_o, reg_rd_en_o}, 0);

    access(1'b1, 4'd1, 32'hA5A5_0001);
    access(1'b0, 4'd2, 32'h0);
    access(1'b0, 4'd7, 32'h0);
    access(1'b1, 4'd9, 32'h1234_5678);
    for (int k = 0; k < NR; k++) access(1'b0, AW'(k), 32'h0);
    access(1'b1, 4'd3, 32'hFFFF_FFFF);
    access(1'b0, 4'd15, 32'h0);

    // Peripheral writes on other slots or during reads leave the count alone.
    periph_wr_en_i = 4'b1001;
    access(1'b1, 4'd1, 32'h0000_0011);
    access(1'b0, 4'd0, 32'h0);
    access(1'b0, 4'd3, 32'h0);
    for (int i = 0; i < 300; i++) access(1'b1, 4'd0, 32'(i));

    // Reset asserted while in RESP.
    access(1'b1, 4'd0, 32'hCAFE_0000);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    cnt_model = '0;
    check_val("rst_resp_ack", ack_o, 0);
    check_val("rst_resp_busy", busy_o, 0);
    check_val("rst_resp_cnt", collision_cnt_o, 0);
    rst_i = 1'b0;
    periph_wr_en_i = '0;
    access(1'b0, 4'd1, 32'h0);

    // Reset asserted in STROBE: the aborted access must not acknowledge.
    wait_idle();
    req_i = 1'b1; we_i = 1'b0; addr_i = 4'd2;
    @(negedge clk);
    req_i = 1'b0; rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check_val("rst_strobe_busy", busy_o, 0);
    check_val("rst_strobe_ack", ack_o, 0);
    access(1'b1, 4'd2, 32'h5555_AAAA);

    // Back-to-back: req held high, addr changing every cycle.
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin @(negedge clk); n++; end
    wait_idle();
    base = ack_cyc.size();
    b2b_addr = '{4'd1, 4'd3, 4'd0, 4'd2, 4'd0, 4'd1, 4'd3, 4'd7, 4'd2};
    for (int i = 0; i < 9; i++) begin
      req_i = 1'b1; we_i = 1'b0; addr_i = b2b_addr[i]; wdata_i = 32'(i);
      if (i % 3 == 0) exp_q.push_back(model(1'b0, b2b_addr[i], 32'(i)));
      @(negedge clk);
    end
    req_i = 1'b0;

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check_val("drain", exp_q.size(), 0);
    if (ack_cyc.size() >= base + 3) begin
      check_val("b2b_gap1", ack_cyc[base+1] - ack_cyc[base], 3);
      check_val("b2b_gap2", ack_cyc[base+2] - ack_cyc[base+1], 3);
    end else begin
      check_val("b2b_ack_count", ack_cyc.size() - base, 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
